// File: rtl/branch_predictor.sv
// Direct-mapped 16-entry branch target buffer with 2-bit counters, resolved in execute.
// Fetch predicts combinationally; execute verifies, retrains and counts branches/mispredicts.
module branch_predictor (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] PCF,
    output logic        PredTakenF,
    output logic [31:0] PredTargetF,
    input  logic        ValidE,
    input  logic        BranchE,
    input  logic        JumpE,
    input  logic        PCSrcE,
    input  logic [31:0] PCE,
    input  logic [31:0] PCTargetE,
    input  logic [31:0] PCPlus4E,
    input  logic        PredTakenE,
    input  logic [31:0] PredTargetE,
    output logic        MispredictE,
    output logic [31:0] RedirectPCE,
    output logic [15:0] BranchCount,
    output logic [15:0] MispredCount
);

    localparam int unsigned Entries = 16;

    logic        valid_q  [Entries];
    logic [25:0] tag_q    [Entries];
    logic [31:0] target_q [Entries];
    logic [1:0]  ctr_q    [Entries];

    logic [15:0] branch_cnt_q, branch_cnt_d;
    logic [15:0] mispred_cnt_q, mispred_cnt_d;

    logic [3:0]  idx_f, idx_e;
    logic        hit_f, hit_e;
    logic        resolve, stale, is_ctrl;

    logic        ent_we;
    logic        ent_valid_d;
    logic [25:0] ent_tag_d;
    logic [31:0] ent_target_d;
    logic [1:0]  ent_ctr_d;

    logic        unused_bits;
    assign unused_bits = ^{PCF[1:0], PCE[1:0]};

    // Fetch lookup reads registered contents only, so same-cycle updates appear next cycle.
    assign idx_f       = PCF[5:2];
    assign hit_f       = valid_q[idx_f] && (tag_q[idx_f] == PCF[31:6]);
    assign PredTakenF  = hit_f & ctr_q[idx_f][1];
    assign PredTargetF = PredTakenF ? target_q[idx_f] : 32'h0;

    assign idx_e   = PCE[5:2];
    assign hit_e   = valid_q[idx_e] && (tag_q[idx_e] == PCE[31:6]);
    assign is_ctrl = BranchE | JumpE;
    assign resolve = ValidE & is_ctrl;
    assign stale   = ValidE & ~is_ctrl & PredTakenE;

    assign MispredictE = ValidE & ((is_ctrl & ((PredTakenE != PCSrcE) |
                                    (PCSrcE & PredTakenE & (PredTargetE != PCTargetE)))) |
                                   (~is_ctrl & PredTakenE));
    assign RedirectPCE = (PCSrcE & is_ctrl) ? PCTargetE : PCPlus4E;

    always_comb begin
        ent_we       = 1'b0;
        ent_valid_d  = valid_q[idx_e];
        ent_tag_d    = tag_q[idx_e];
        ent_target_d = target_q[idx_e];
        ent_ctr_d    = ctr_q[idx_e];
        if (resolve) begin
            if (hit_e) begin
                ent_we = 1'b1;
                if (JumpE) begin
                    ent_ctr_d = 2'b11;
                end else if (PCSrcE) begin
                    ent_ctr_d = (ctr_q[idx_e] == 2'b11) ? 2'b11 : ctr_q[idx_e] + 2'd1;
                end else begin
                    ent_ctr_d = (ctr_q[idx_e] == 2'b00) ? 2'b00 : ctr_q[idx_e] - 2'd1;
                end
                if (PCSrcE) begin
                    ent_target_d = PCTargetE;
                end
            end else if (PCSrcE) begin
                ent_we       = 1'b1;
                ent_valid_d  = 1'b1;
                ent_tag_d    = PCE[31:6];
                ent_target_d = PCTargetE;
                ent_ctr_d    = JumpE ? 2'b11 : 2'b10;
            end
        end else if (stale) begin
            ent_we      = 1'b1;
            ent_valid_d = 1'b0;
        end
    end

    always_comb begin
        branch_cnt_d  = branch_cnt_q;
        mispred_cnt_d = mispred_cnt_q;
        if (resolve && branch_cnt_q != 16'hFFFF) begin
            branch_cnt_d = branch_cnt_q + 16'd1;
        end
        if (MispredictE && mispred_cnt_q != 16'hFFFF) begin
            mispred_cnt_d = mispred_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < Entries; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= 26'h0;
                target_q[i] <= 32'h0;
                ctr_q[i]    <= 2'b00;
            end
            branch_cnt_q  <= 16'h0;
            mispred_cnt_q <= 16'h0;
        end else begin
            if (ent_we) begin
                valid_q[idx_e]  <= ent_valid_d;
                tag_q[idx_e]    <= ent_tag_d;
                target_q[idx_e] <= ent_target_d;
                ctr_q[idx_e]    <= ent_ctr_d;
            end
            branch_cnt_q  <= branch_cnt_d;
            mispred_cnt_q <= mispred_cnt_d;
        end
    end

    assign BranchCount  = branch_cnt_q;
    assign MispredCount = mispred_cnt_q;

endmodule

// File: doc/branch_predictor.md
BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 The block SHALL have exactly one clock; reset is synchronous and active-high.
REQ-002 The block SHALL expose these ports, in this order:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- PCF  in  32  fetch-stage PC.
- PredTakenF  out  1  fetch predicts redirect.
- PredTargetF  out  32  predicted target; 32'h0 when PredTakenF=0.
- ValidE  in  1  execute stage holds a real, non-bubble instruction.
- BranchE  in  1  execute instruction is a conditional branch (op 1100011).
- JumpE  in  1  execute instruction is jal/jalr (op 1101111/1100111).
- PCSrcE  in  1  resolved taken, from the branch decision logic.
- PCE  in  32  execute-stage PC.
- PCTargetE  in  32  resolved target.
- PCPlus4E  in  32  PCE+4.
- PredTakenE  in  1  PredTakenF carried down the pipeline.
- PredTargetE  in  32  PredTargetF carried down the pipeline.
- MispredictE  out  1  flush F/D and redirect fetch.
- RedirectPCE  out  32  correct next PC when MispredictE=1.
- BranchCount  out  16  resolved branch/jump count.
- MispredCount  out  16  mispredict count.

Function
REQ-003 The table SHALL have 16 entries indexed by PC[5:2]; each entry holds valid, tag=PC[31:6], target[31:0] and a 2-bit counter.
REQ-004 A fetch hit SHALL be valid & tag==PCF[31:6] at index PCF[5:2]; PredTakenF = hit & counter[1]; PredTargetF = target when PredTakenF=1, else 32'h0; both combinational.
REQ-005 Table reads SHALL see pre-edge contents: a same-cycle update to the same index is visible to fetch only from the next cycle.
REQ-006 A resolve event SHALL be ValidE & (BranchE | JumpE); the table, counters and MispredictE SHALL ignore execute inputs when ValidE=0.
REQ-007 On a resolve event that hits at index PCE[5:2]:
- counter SHALL saturating-increment if PCSrcE=1 (max 2'b11) and saturating-decrement if PCSrcE=0 (min 2'b00).
- target SHALL be written with PCTargetE when PCSrcE=1.
- JumpE SHALL force counter to 2'b11.
REQ-008 On a resolve event that misses with PCSrcE=1, the block SHALL allocate or overwrite the entry: valid=1, tag=PCE[31:6], target=PCTargetE, counter=2'b10 for a branch or 2'b11 for a jump.
REQ-009 On a resolve event that misses with PCSrcE=0, the table SHALL NOT change.
REQ-010 MispredictE SHALL be combinational: ValidE & ( (BranchE|JumpE) & ((PredTakenE != PCSrcE) | (PCSrcE & PredTakenE & PredTargetE != PCTargetE)) | (~BranchE & ~JumpE & PredTakenE) ).
REQ-011 A stale prediction on a non-branch/non-jump (ValidE & ~BranchE & ~JumpE & PredTakenE) SHALL clear valid of entry PCE[5:2] on the next edge.
REQ-012 RedirectPCE SHALL be PCTargetE when PCSrcE & (BranchE|JumpE), else PCPlus4E.
REQ-013 BranchCount SHALL increment by 1 per resolve event.
REQ-014 MispredCount SHALL increment by 1 per cycle with MispredictE=1.
REQ-015 BranchCount and MispredCount SHALL both saturate at 16'hFFFF.
REQ-016 The block SHALL have zero-cycle prediction latency and a one-edge update latency, and SHALL contain no internal stall state.

Reset
REQ-017 While reset=1 at a clock edge, all valid bits, counters, targets and tags SHALL clear to 0, and BranchCount and MispredCount SHALL clear to 16'h0.
REQ-018 After reset, PredTakenF=0, PredTargetF=32'h0, and MispredictE=0 when ValidE=0.
REQ-019 Reset SHALL override any same-cycle resolve event, and reset asserted mid-sequence SHALL discard all training.

Verification
REQ-020 Cold taken branch: after reset, PCE=0x100, BranchE=1, PCSrcE=1, PCTargetE=0x80, PredTakenE=0 -> MispredictE=1, RedirectPCE=0x80; the next cycle PCF=0x100 gives PredTakenF=1, PredTargetF=0x80.
REQ-021 Counter hysteresis: after REQ-020, resolve 0x100 not-taken once -> counter=01, PredTakenF=0 at 0x100; two not-taken resolves -> counter=00, stays 00; a taken resolve -> counter=01, still not predicted.
REQ-022 Aliasing: entry trained at 0x100; PCF=0x1100 (same index, different tag) -> PredTakenF=0; a taken jal at 0x1100 to 0x2000 overwrites the entry with counter=11.
REQ-023 Stale/target mismatch: PredTakenE=1, PredTargetE=0x80, PCSrcE=1, PCTargetE=0x90 -> MispredictE=1, RedirectPCE=0x90. PredTakenE=1 on a non-branch -> MispredictE=1, RedirectPCE=PCPlus4E, entry invalidated.
REQ-024 Same-cycle read/write: update and fetch at index 5 in one cycle -> fetch sees the old entry that cycle and the new entry the next cycle. ValidE=0 with BranchE=1 -> no counter, table or MispredictE change.
REQ-025 Saturation/reset: 70000 resolve events -> BranchCount=16'hFFFF and it holds; reset asserted mid-run -> counters 0, all predictions not-taken.
